// File: rtl/i2s_pkg.sv
// Shared parameters and capture FSM encoding for the RPi sample receiver.
package i2s_pkg;

    localparam int DATA_W     = 24;
    localparam int DEPTH_LOG2 = 6;
    localparam int IRQ_LEVEL  = 32;

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LVL_W = DEPTH_LOG2 + 1;
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } cap_state_e;

endpackage

// File: rtl/i2s_rx_buffer_ctrl_if.sv
// Word stream from the sample buffer to the downstream consumer.
interface i2s_rx_buffer_ctrl_if #(
    parameter int DATA_W = i2s_pkg::DATA_W
);

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );

endinterface

// File: rtl/sync_edge_det.sv
// Two-flop synchronizers for the RPi bit clock and data line,
// plus a rising-edge strobe on the synchronized bit clock.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic bclk,
    input  logic din,
    output logic strobe,
    output logic dout
);

    logic [1:0] c_sync;
    logic [1:0] d_sync;
    logic       c_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_sync <= '0;
            d_sync <= '0;
            c_prev <= 1'b0;
        end else begin
            c_sync <= {c_sync[0], bclk};
            d_sync <= {d_sync[0], din};
            c_prev <= c_sync[1];
        end
    end

    assign strobe = c_sync[1] & ~c_prev;
    assign dout   = d_sync[1];

endmodule

// File: rtl/i2s_rx_buffer_ctrl.sv
// Captures 24-bit LSB-first words from the RPi pins into a 64-entry
// circular buffer and serves them over a valid/ready stream.
import i2s_pkg::*;

module i2s_rx_buffer_ctrl #(
    parameter int DATA_W     = i2s_pkg::DATA_W,
    parameter int DEPTH_LOG2 = i2s_pkg::DEPTH_LOG2,
    parameter int IRQ_LEVEL  = i2s_pkg::IRQ_LEVEL
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    rpi_clk,
    input  logic                    serial,
    i2s_rx_buffer_ctrl_if.master    out,
    output logic                    rpi_interrupt,
    output logic                    overflow,
    output logic [DEPTH_LOG2:0]     level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LVL_W = DEPTH_LOG2 + 1;
    localparam int BCW   = $clog2(DATA_W);

    cap_state_e            state;
    logic [BCW-1:0]        bit_cnt;
    logic [DATA_W-1:0]     asm_q;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  en_q;
    logic [DATA_W-1:0]     mem [DEPTH];

    logic strobe;
    logic ser_s;
    logic valid;
    logic pop;
    logic full;
    logic commit;
    logic push;
    logic drop;

    sync_edge_det u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .bclk   (rpi_clk),
        .din    (serial),
        .strobe (strobe),
        .dout   (ser_s)
    );

    assign valid  = (level != '0);
    assign pop    = valid && out.out_ready;
    assign full   = (level == LVL_W'(DEPTH));
    assign commit = (state == COMMIT);
    // A pop in the same cycle frees the slot the new word needs.
    assign push   = commit && (!full || pop);
    assign drop   = commit && full && !pop;

    assign out.out_valid = valid;
    assign out.out_data  = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            asm_q         <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            en_q          <= 1'b0;
            overflow      <= 1'b0;
            rpi_interrupt <= 1'b0;
        end else begin
            en_q          <= enable;
            rpi_interrupt <= (level < LVL_W'(IRQ_LEVEL)) && enable;
            if (enable && !en_q) begin
                overflow <= 1'b0;
            end
            if (!enable) begin
                state   <= IDLE;
                bit_cnt <= '0;
            end else begin
                unique case (state)
                    IDLE: state <= SHIFT;
                    SHIFT: begin
                        if (strobe) begin
                            asm_q[bit_cnt] <= ser_s;
                            if (bit_cnt == BCW'(DATA_W - 1)) begin
                                bit_cnt <= '0;
                                state   <= COMMIT;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    COMMIT: state <= SHIFT;
                    default: state <= IDLE;
                endcase
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
        end
    end

    // Storage carries no reset; it is only observable while level != 0.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= asm_q;
        end
    end

endmodule

// File: tb/tb_i2s_rx_buffer_ctrl.sv
// Random-word bench for i2s_rx_buffer_ctrl against a queue model.
`timescale 1ns/1ps
module tb_i2s_rx_buffer_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       rpi_clk;
    logic       serial;
    logic       rpi_interrupt;
    logic       overflow;
    logic [6:0] level;

    i2s_rx_buffer_ctrl_if bus ();

    i2s_rx_buffer_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .rpi_clk       (rpi_clk),
        .serial        (serial),
        .out           (bus),
        .rpi_interrupt (rpi_interrupt),
        .overflow      (overflow),
        .level         (level)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [23:0] q[$];
    logic        m_ovf = 1'b0;
    logic        m_en  = 1'b0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".level"}, level, q.size());
        chk({tag, ".valid"}, bus.out_valid, q.size() != 0);
        if (q.size() != 0) chk({tag, ".data"}, bus.out_data, q[0]);
        chk({tag, ".ovf"}, overflow, m_ovf);
        chk({tag, ".irq"}, rpi_interrupt, m_en && (q.size() < 32));
    endtask

    task automatic model_push(input logic [23:0] w);
        if (q.size() < 64) q.push_back(w);
        else m_ovf = 1'b1;
    endtask

    task automatic bit_rise(input logic b);
        serial  = b;
        rpi_clk = 1'b0;
        repeat (4) @(negedge clk);
        rpi_clk = 1'b1;
    endtask

    task automatic send_head(input logic [23:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            bit_rise(w[i]);
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic send_word(input logic [23:0] w, input string tag);
        send_head(w, 24);
        rpi_clk = 1'b0;
        repeat (4) @(negedge clk);
        model_push(w);
        check_state(tag);
    endtask

    task automatic pop_one(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        void'(q.pop_front());
        @(negedge clk);
        check_state(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] w;
        logic        seen;
        rst_n = 1'b0;
        enable = 1'b0;
        rpi_clk = 1'b0;
        serial = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.data", bus.out_data, 0);
        check_state("rst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_state("post_rst");

        enable = 1'b1;
        m_en = 1'b1;
        repeat (3) @(negedge clk);
        check_state("en");

        send_word(24'hA5C3F1, "single");
        pop_one("single_pop");

        for (int i = 0; i < 31; i++) send_word(24'($urandom), "fill31");
        w = 24'($urandom);
        send_head(w, 23);
        bit_rise(w[23]);
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            if (level == 7'd32) seen = 1'b1;
        end
        chk("lvl32_seen", seen, 1);
        chk("irq_pre", rpi_interrupt, 1);
        @(negedge clk);
        chk("irq_fall", rpi_interrupt, 0);
        rpi_clk = 1'b0;
        repeat (4) @(negedge clk);
        model_push(w);
        check_state("w32");
        pop_one("irq_rise");

        while (q.size() < 64) send_word(24'($urandom), "fill64");
        send_word(24'($urandom), "ovf65");
        while (q.size() > 0) pop_one("drain");
        for (int i = 0; i < 10; i++) send_word(24'($urandom), "wrap");
        while (q.size() > 0) pop_one("wrap_drain");

        send_head(24'($urandom), 12);
        rpi_clk = 1'b0;
        repeat (2) @(negedge clk);
        enable = 1'b0;
        m_en = 1'b0;
        repeat (4) @(negedge clk);
        check_state("en_off");
        enable = 1'b1;
        m_en = 1'b1;
        m_ovf = 1'b0;
        repeat (3) @(negedge clk);
        check_state("en_on");
        send_word(24'h000001, "after_drop");

        while (q.size() < 64) send_word(24'($urandom), "refill");
        w = 24'($urandom);
        send_head(w, 23);
        bit_rise(w[23]);
        repeat (3) @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        rpi_clk = 1'b0;
        repeat (4) @(negedge clk);
        void'(q.pop_front());
        q.push_back(w);
        check_state("full_pushpop");
        while (q.size() > 0) pop_one("drain2");

        for (int i = 0; i < 5; i++) send_word(24'($urandom), "pre_rst");
        send_head(24'($urandom), 10);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.level", level, 0);
        chk("arst.valid", bus.out_valid, 0);
        chk("arst.data", bus.out_data, 0);
        chk("arst.irq", rpi_interrupt, 0);
        chk("arst.ovf", overflow, 0);
        q.delete();
        m_ovf = 1'b0;
        @(negedge clk);
        rpi_clk = 1'b0;
        serial = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_state("post_arst");
        send_word(24'($urandom), "clean");

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/i2s_rx_buffer_ctrl.md
# i2s_rx_buffer_ctrl

Single-clock controller for the RPi-to-FPGA sample path. Synchronizes the RPi bit clock and serial line into `clk`, assembles 24-bit words LSB-first, and writes them into a 64-entry circular sample buffer. It sequences write and read pointers, serves words to the downstream consumer over a valid/ready handshake, and raises `rpi_interrupt` to request more data while buffer space is available. It sits between the RPi GPIO pins and the audio output stage.

## Interface
- `DATA_W`, 24: sample word width.
- `DEPTH_LOG2`, 6: buffer depth = 2^DEPTH_LOG2 = 64 entries.
- `IRQ_LEVEL`, 32: occupancy threshold for `rpi_interrupt`.

Ports:
- `clk` input 1: system clock. One clock; everything in this block runs on it.
- `rst_n` input 1: reset, asynchronous and active-low.
- `enable` input 1: capture enable (synchronous level).
- `rpi_clk` input 1: raw RPi bit clock, asynchronous to `clk`.
- `serial` input 1: raw RPi data bit, asynchronous to `clk`.
- `out_ready` input 1: consumer accepts a word this cycle.
- `out_valid` output 1: `out_data` holds a valid buffered word.
- `out_data` output DATA_W: oldest buffered word.
- `rpi_interrupt` output 1: registered request for more data from the RPi.
- `overflow` output 1: sticky flag; a completed word was dropped because the buffer was full.
- `level` output DEPTH_LOG2+1: current occupancy, 0..64.

## Operation
- **Input conditioning.** `rpi_clk` and `serial` each pass through 2-flop synchronizers of equal depth. A bit strobe fires on the synchronized `rpi_clk` rising edge.
- **Capture FSM states:**
  - IDLE: entered when `enable`=0.
  - SHIFT: entered from IDLE when `enable`=1.
  - COMMIT: one cycle, after the 24th bit.
- **Transitions:**
  - IDLE→SHIFT when `enable`=1.
  - In SHIFT, each strobe writes the synchronized `serial` into bit `bit_cnt` of the assembly register, then increments `bit_cnt`. Bit 0 is received first.
  - When the strobe that sets bit DATA_W-1 arrives, go to COMMIT.
  - COMMIT→SHIFT unconditionally, with `bit_cnt`=0.
  - `enable`=0 in any state → IDLE next cycle: `bit_cnt`=0, partial word discarded.
- **Push (in COMMIT).**
  - If `level`<64, or a pop happens in the same cycle: write `mem[wr_ptr]` and increment `wr_ptr`.
  - Otherwise drop the word and set `overflow`.
- **Pop.** When `out_valid` && `out_ready`: increment `rd_ptr`.
- **Outputs.** `out_valid` = (`level`!=0). `out_data` = `mem[rd_ptr]`, read combinationally from the storage register.
- **Level accounting.** `level` does +1 on push only, −1 on pop only, and is unchanged on simultaneous push and pop.
- **Pointers.** `wr_ptr` and `rd_ptr` are DEPTH_LOG2 bits and wrap 63→0 naturally.
- **Full condition.** `level`==64 is full, which disambiguates `wr_ptr`==`rd_ptr`.
- **Overflow clear.** `overflow` clears on an `enable` 0→1 transition or on reset.
- **Interrupt.** `rpi_interrupt` is registered as (`level` < IRQ_LEVEL) && `enable`.
- **Buffer retention.** Buffer contents and the read side are unaffected by `enable`. The consumer can drain after capture stops.

## Timing
- **Reset values (`rst_n`=0):**
  - FSM=IDLE; `bit_cnt`, `wr_ptr`, `rd_ptr`, `level` = 0.
  - `out_valid`=0, `out_data`=0, `rpi_interrupt`=0, `overflow`=0.
  - Synchronizer flops = 0.
  - Memory is not reset, and is not observable while `level`=0.
- **Pin-to-strobe latency.** From `rpi_clk` pin edge to sample strobe: 3 `clk` cycles (2 sync + edge detect).
- **Commit latency.**
  - 24th strobe cycle → COMMIT next cycle → mem write at the end of COMMIT.
  - `out_valid`/`level` update visible in the cycle after COMMIT.
  - `rpi_interrupt` updates one cycle after `level`.
- **Bit-clock rate.** `rpi_clk` high and low phases must each be ≥2 `clk` periods, so `rpi_clk` ≤ `clk`/4. Faster input is unsupported.
- **Pop timing.** Pop takes effect at the `clk` edge where `out_valid` && `out_ready`. The next word is visible the same cycle `rd_ptr` updates.
- **Full with simultaneous pop.** Push at full with a simultaneous pop is accepted: `level` stays 64, no overflow.
- **Asynchronous reset mid-word** clears the partial word and all pointers immediately.

## Structure
- **Package `i2s_pkg`:**
  - `DATA_W`, `DEPTH_LOG2`, `IRQ_LEVEL` defaults.
  - Capture FSM state enum: IDLE, SHIFT, COMMIT.
  - Level/pointer width derivations.
- **Sub-module `sync_edge_det`:**
  - 2-flop synchronizer plus rising-edge detect.
  - Instantiated for `rpi_clk`; `serial` uses its synchronizer-only output.
- Storage array, pointers and FSM stay in the top module.

## Test plan
- **Single word:** reset, `enable`=1, shift 0xA5C3F1 LSB-first at `clk`/8 → one cycle after COMMIT, `out_valid`=1, `out_data`=0xA5C3F1, `level`=1; pop → `level`=0, `out_valid`=0.
- **Interrupt threshold:** push 31 words with `out_ready`=0 → `rpi_interrupt`=1; 32nd word → `rpi_interrupt` falls 1 cycle after `level`=32; pop one → rises again.
- **Full/overflow and wrap:**
  - Push 64 words → `level`=64.
  - 65th word with `out_ready`=0 → dropped, `overflow`=1, `level`=64.
  - Drain all → words 0..63 in order.
  - Push 10 more → pointers wrap, data intact.
- **Simultaneous push/pop at full:** `out_ready`=1 during COMMIT with `level`=64 → `level` stays 64, `overflow` stays 0, oldest word consumed.
- **Enable drop mid-word:** `enable`=0 after 12 bits, then re-enable and send 0x000001 → only 0x000001 is buffered; `overflow` cleared on re-enable.
- **Async reset:** assert `rst_n`=0 mid-word with `level`=5 → all outputs at reset values within the same cycle; next full word is received cleanly.
